// File: rtl/time_slot_pkg.sv
// ----------------------------------------------------------------------------
// time_slot_pkg
// Shared definitions for the time-slot frame sequencer:
//   state_t      - sequencer FSM states (IDLE, SLOT, GAP)
//   clog2()      - ceiling log2, used to size slot-index buses
//   SLOT_W       - slot-index width for the default 4-slot configuration
// ----------------------------------------------------------------------------
package time_slot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Smallest r with 2**r >= n (n = 1 gives 0).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int DEF_N_SLOTS = 4;
    localparam int SLOT_W      = clog2(DEF_N_SLOTS);

endpackage

// File: rtl/tss_next_slot.sv
// ----------------------------------------------------------------------------
// tss_next_slot
// Combinational slot picker.
// Ports:
//   i_mask   in   N_SLOTS     one bit per slot, 1 = slot has nonzero length
//   i_cur    in   SLOT_IDX_W  index of the current slot
//   o_next   out  SLOT_IDX_W  lowest valid index strictly above i_cur
//   o_found  out  1           o_next is valid
//   o_low    out  SLOT_IDX_W  lowest valid index overall
//   o_any    out  1           at least one valid slot exists
// ----------------------------------------------------------------------------
module tss_next_slot
    import time_slot_pkg::*;
#(
    parameter int N_SLOTS = 4
) (
    input  logic [N_SLOTS-1:0]        i_mask,
    input  logic [clog2(N_SLOTS)-1:0] i_cur,
    output logic [clog2(N_SLOTS)-1:0] o_next,
    output logic                      o_found,
    output logic [clog2(N_SLOTS)-1:0] o_low,
    output logic                      o_any
);

    localparam int SLOT_IDX_W = clog2(N_SLOTS);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        o_low   = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (i_mask[k]) begin
                o_low = SLOT_IDX_W'(k);
                if (SLOT_IDX_W'(k) > i_cur) begin
                    o_next  = SLOT_IDX_W'(k);
                    o_found = 1'b1;
                end
            end
        end
        o_any = |i_mask;
    end

endmodule

// File: rtl/time_slot_seq.sv
// ----------------------------------------------------------------------------
// time_slot_seq
// Frame sequencer: on i_sync walks the nonzero-length slots in ascending
// index order, optionally separated by an idle gap, for 1 + repeat passes.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_sync           frame start / restart pulse (latches i_len/i_gap/i_repeat)
//   i_abort          stop the sequence, wins over a simultaneous i_sync
//   i_len            packed slot lengths, slot k = [k*LEN_W +: LEN_W], 0 = skip
//   i_gap            idle cycles between active slots and between passes
//   i_repeat         extra passes after the first
//   o_slot           current slot index, held while idle or in a gap
//   o_slot_active    high on slot cycles
//   o_slot_sync      pulse on the first cycle of each slot
//   o_frame_sync     pulse on the first slot cycle of each pass
//   o_complete       pulse when the sequence ends normally
//   o_busy           high from the first slot cycle until the sequence ends
//   o_tick           cycle index within the slot, 0 outside slots
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module time_slot_seq
    import time_slot_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int LEN_W   = 16,
    parameter int GAP_W   = 8,
    parameter int REP_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_sync,
    input  logic                       i_abort,
    input  logic [N_SLOTS*LEN_W-1:0]   i_len,
    input  logic [GAP_W-1:0]           i_gap,
    input  logic [REP_W-1:0]           i_repeat,
    output logic [clog2(N_SLOTS)-1:0]  o_slot,
    output logic                       o_slot_active,
    output logic                       o_slot_sync,
    output logic                       o_frame_sync,
    output logic                       o_complete,
    output logic                       o_busy,
    output logic [LEN_W-1:0]           o_tick
);

    localparam int SW = clog2(N_SLOTS);

    state_t                   r_state, w_state_nxt;
    logic [SW-1:0]            r_slot, w_slot_nxt;
    logic [SW-1:0]            r_pend_slot, w_pend_slot_nxt;
    logic                     r_pend_frame, w_pend_frame_nxt;
    logic [LEN_W-1:0]         r_tick, w_tick_nxt;
    logic [GAP_W-1:0]         r_gap_cnt, w_gap_cnt_nxt;
    logic [REP_W-1:0]         r_pass, w_pass_nxt;
    logic [N_SLOTS*LEN_W-1:0] r_len_sh, w_len_sh_nxt;
    logic [GAP_W-1:0]         r_gap_sh, w_gap_sh_nxt;
    logic [REP_W-1:0]         r_rep_sh, w_rep_sh_nxt;
    logic                     r_active, w_active_nxt;
    logic                     r_slot_sync, w_slot_sync_nxt;
    logic                     r_frame_sync, w_frame_sync_nxt;
    logic                     r_complete, w_complete_nxt;
    logic                     r_busy, w_busy_nxt;

    logic [LEN_W-1:0]         w_len_arr [N_SLOTS];
    logic [N_SLOTS-1:0]       w_sh_mask, w_in_mask, w_mask_sel;
    logic [LEN_W-1:0]         w_cur_len;
    logic                     w_slot_last, w_gap_last;
    logic [SW-1:0]            w_next_idx, w_low_idx;
    logic                     w_next_found, w_low_any;

    always_comb begin
        for (int k = 0; k < N_SLOTS; k++) begin
            w_len_arr[k] = r_len_sh[k*LEN_W +: LEN_W];
            w_sh_mask[k] = |r_len_sh[k*LEN_W +: LEN_W];
            w_in_mask[k] = |i_len[k*LEN_W +: LEN_W];
        end
    end

    // On a sync cycle the lowest slot must come from the incoming lengths,
    // otherwise from the latched ones; a single picker serves both.
    assign w_mask_sel = i_sync ? w_in_mask : w_sh_mask;

    tss_next_slot #(
        .N_SLOTS (N_SLOTS)
    ) u_next_slot (
        .i_mask  (w_mask_sel),
        .i_cur   (r_slot),
        .o_next  (w_next_idx),
        .o_found (w_next_found),
        .o_low   (w_low_idx),
        .o_any   (w_low_any)
    );

    // Compares are one bit wider so L = 2**LEN_W-1 (and G = 2**GAP_W-1) work.
    assign w_cur_len   = w_len_arr[r_slot];
    assign w_slot_last = (({1'b0, r_tick} + (LEN_W+1)'(1)) == {1'b0, w_cur_len});
    assign w_gap_last  = (({1'b0, r_gap_cnt} + (GAP_W+1)'(1)) == {1'b0, r_gap_sh});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_slot       <= '0;
            r_pend_slot  <= '0;
            r_pend_frame <= 1'b0;
            r_tick       <= '0;
            r_gap_cnt    <= '0;
            r_pass       <= '0;
            r_len_sh     <= '0;
            r_gap_sh     <= '0;
            r_rep_sh     <= '0;
            r_active     <= 1'b0;
            r_slot_sync  <= 1'b0;
            r_frame_sync <= 1'b0;
            r_complete   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_pend_slot  <= w_pend_slot_nxt;
            r_pend_frame <= w_pend_frame_nxt;
            r_tick       <= w_tick_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_pass       <= w_pass_nxt;
            r_len_sh     <= w_len_sh_nxt;
            r_gap_sh     <= w_gap_sh_nxt;
            r_rep_sh     <= w_rep_sh_nxt;
            r_active     <= w_active_nxt;
            r_slot_sync  <= w_slot_sync_nxt;
            r_frame_sync <= w_frame_sync_nxt;
            r_complete   <= w_complete_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_slot_nxt       = r_slot;
        w_pend_slot_nxt  = r_pend_slot;
        w_pend_frame_nxt = r_pend_frame;
        w_tick_nxt       = r_tick;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_pass_nxt       = r_pass;
        w_len_sh_nxt     = r_len_sh;
        w_gap_sh_nxt     = r_gap_sh;
        w_rep_sh_nxt     = r_rep_sh;
        w_active_nxt     = r_active;
        w_busy_nxt       = r_busy;
        w_slot_sync_nxt  = 1'b0;
        w_frame_sync_nxt = 1'b0;
        w_complete_nxt   = 1'b0;

        if (i_abort) begin
            w_state_nxt  = IDLE;
            w_active_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_tick_nxt   = '0;
        end else if (i_sync) begin
            w_len_sh_nxt = i_len;
            w_gap_sh_nxt = i_gap;
            w_rep_sh_nxt = i_repeat;
            w_pass_nxt   = '0;
            w_tick_nxt   = '0;
            if (w_low_any) begin
                w_state_nxt      = SLOT;
                w_slot_nxt       = w_low_idx;
                w_active_nxt     = 1'b1;
                w_busy_nxt       = 1'b1;
                w_slot_sync_nxt  = 1'b1;
                w_frame_sync_nxt = 1'b1;
            end else begin
                // Nothing to play: finish immediately without going busy.
                w_state_nxt    = IDLE;
                w_active_nxt   = 1'b0;
                w_busy_nxt     = 1'b0;
                w_complete_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                SLOT: begin
                    if (!w_slot_last) begin
                        w_tick_nxt = r_tick + LEN_W'(1);
                    end else if (!w_next_found && (r_pass == r_rep_sh)) begin
                        w_state_nxt    = IDLE;
                        w_active_nxt   = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_tick_nxt     = '0;
                        w_complete_nxt = 1'b1;
                    end else begin
                        // Either a higher slot in this pass, or wrap to the
                        // lowest slot of the next pass.
                        w_tick_nxt = '0;
                        if (w_next_found) begin
                            w_pend_slot_nxt  = w_next_idx;
                            w_pend_frame_nxt = 1'b0;
                        end else begin
                            w_pend_slot_nxt  = w_low_idx;
                            w_pend_frame_nxt = 1'b1;
                            w_pass_nxt       = r_pass + REP_W'(1);
                        end
                        if (r_gap_sh != '0) begin
                            w_state_nxt   = GAP;
                            w_gap_cnt_nxt = '0;
                            w_active_nxt  = 1'b0;
                        end else begin
                            w_state_nxt      = SLOT;
                            w_slot_nxt       = w_pend_slot_nxt;
                            w_slot_sync_nxt  = 1'b1;
                            w_frame_sync_nxt = w_pend_frame_nxt;
                        end
                    end
                end
                GAP: begin
                    if (w_gap_last) begin
                        w_state_nxt      = SLOT;
                        w_slot_nxt       = r_pend_slot;
                        w_active_nxt     = 1'b1;
                        w_slot_sync_nxt  = 1'b1;
                        w_frame_sync_nxt = r_pend_frame;
                        w_tick_nxt       = '0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign o_slot        = r_slot;
    assign o_slot_active = r_active;
    assign o_slot_sync   = r_slot_sync;
    assign o_frame_sync  = r_frame_sync;
    assign o_complete    = r_complete;
    assign o_busy        = r_busy;
    assign o_tick        = r_tick;

endmodule

// File: tb/tb_time_slot_seq.sv
// ----------------------------------------------------------------------------
// tb_time_slot_seq
// Directed bench for time_slot_seq: a 4-slot/16-bit instance (a_*) and a
// 16-slot/4-bit instance (b_*). Expected output words per cycle are built
// from the frame description (slot list, gap, repeat) when a sync is driven.
// Word layout: {busy, active, slot_sync, frame_sync, complete, slot[3:0],
// tick[15:0]}.
// ----------------------------------------------------------------------------
module tb_time_slot_seq;

    logic clk;
    logic rst_n;

    logic        a_sync, a_abort;
    logic [63:0] a_len;
    logic [7:0]  a_gap, a_rep;
    logic [1:0]  a_slot;
    logic        a_active, a_ss, a_fs, a_cp, a_busy;
    logic [15:0] a_tick;

    logic        b_sync, b_abort;
    logic [63:0] b_len;
    logic [7:0]  b_gap, b_rep;
    logic [3:0]  b_slot;
    logic        b_active, b_ss, b_fs, b_cp, b_busy;
    logic [3:0]  b_tick;

    logic [24:0] exp_q[$];
    int          n_checks;
    int          n_pass;
    int          n_fail;
    int          cur_sel;
    int          cyc_idx;
    int          last_slot[2];
    string       cur_tag;

    time_slot_seq #(.N_SLOTS(4), .LEN_W(16), .GAP_W(8), .REP_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_sync(a_sync), .i_abort(a_abort),
        .i_len(a_len), .i_gap(a_gap), .i_repeat(a_rep),
        .o_slot(a_slot), .o_slot_active(a_active), .o_slot_sync(a_ss),
        .o_frame_sync(a_fs), .o_complete(a_cp), .o_busy(a_busy), .o_tick(a_tick)
    );

    time_slot_seq #(.N_SLOTS(16), .LEN_W(4), .GAP_W(8), .REP_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_sync(b_sync), .i_abort(b_abort),
        .i_len(b_len), .i_gap(b_gap), .i_repeat(b_rep),
        .o_slot(b_slot), .o_slot_active(b_active), .o_slot_sync(b_ss),
        .o_frame_sync(b_fs), .o_complete(b_cp), .o_busy(b_busy), .o_tick(b_tick)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    function automatic logic [24:0] obs_vec(input int sel);
        if (sel == 0) begin
            return {a_busy, a_active, a_ss, a_fs, a_cp, 2'b00, a_slot, a_tick};
        end
        return {b_busy, b_active, b_ss, b_fs, b_cp, b_slot, 12'h000, b_tick};
    endfunction

    task automatic push_vec(input bit busy, input bit act, input bit ss,
                            input bit fs, input bit cp, input int slot, input int tick);
        exp_q.push_back({busy, act, ss, fs, cp, 4'(slot), 16'(tick)});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            push_vec(0, 0, 0, 0, 0, last_slot[cur_sel], 0);
        end
    endtask

    // Expand a frame description into the per-cycle expected words,
    // starting at the cycle after the sync edge.
    task automatic build_trace(input int lens[16], input int n, input int gap, input int rep);
        int act[$];
        int hold;
        bit first;
        hold = last_slot[cur_sel];
        for (int k = 0; k < n; k++) begin
            if (lens[k] != 0) act.push_back(k);
        end
        if (act.size() == 0) begin
            push_vec(0, 0, 0, 0, 1, hold, 0);
            for (int i = 0; i < 2; i++) push_vec(0, 0, 0, 0, 0, hold, 0);
            return;
        end
        first = 1'b1;
        for (int p = 0; p <= rep; p++) begin
            for (int j = 0; j < act.size(); j++) begin
                if (!first) begin
                    for (int g = 0; g < gap; g++) push_vec(1, 0, 0, 0, 0, hold, 0);
                end
                first = 1'b0;
                for (int t = 0; t < lens[act[j]]; t++) begin
                    push_vec(1, 1, t == 0, (t == 0) && (j == 0), 0, act[j], t);
                end
                hold = act[j];
            end
        end
        push_vec(0, 0, 0, 0, 1, hold, 0);
        for (int i = 0; i < 2; i++) push_vec(0, 0, 0, 0, 0, hold, 0);
    endtask

    task automatic check_now();
        logic [24:0] e;
        logic [24:0] o;
        n_checks++;
        cyc_idx++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s[%0d] expected queue empty", cur_tag, cyc_idx);
            return;
        end
        e = exp_q.pop_front();
        o = obs_vec(cur_sel);
        last_slot[cur_sel] = int'(e[19:16]);
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[%0d] observed flags(busy,act,ss,fs,cp)=%b slot=%0d tick=%0d expected flags=%b slot=%0d tick=%0d",
                   cur_tag, cyc_idx, o[24:20], o[19:16], o[15:0], e[24:20], e[19:16], e[15:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step_check();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            step_check();
            guard++;
        end
    endtask

    task automatic set_tag(input string t, input int sel);
        cur_tag = t;
        cur_sel = sel;
        cyc_idx = 0;
    endtask

    task automatic load_a(input int l0, input int l1, input int l2, input int l3,
                          input int g, input int r, input bit push);
        int lv[16];
        lv = '{default: 0};
        lv[0] = l0; lv[1] = l1; lv[2] = l2; lv[3] = l3;
        a_len = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
        a_gap = 8'(g);
        a_rep = 8'(r);
        if (push) build_trace(lv, 4, g, r);
    endtask

    task automatic load_b(input int lv[16], input int g, input int r);
        for (int k = 0; k < 16; k++) b_len[k*4 +: 4] = 4'(lv[k]);
        b_gap = 8'(g);
        b_rep = 8'(r);
        build_trace(lv, 16, g, r);
    endtask

    task automatic sync_pulse();
        if (cur_sel == 0) a_sync = 1'b1;
        else              b_sync = 1'b1;
        step_check();
        a_sync = 1'b0;
        b_sync = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lv[16];
        n_checks = 0; n_pass = 0; n_fail = 0; cyc_idx = 0;
        last_slot[0] = 0; last_slot[1] = 0;
        cur_sel = 0; cur_tag = "reset";
        a_sync = 0; a_abort = 0; a_len = '0; a_gap = '0; a_rep = '0;
        b_sync = 0; b_abort = 0; b_len = '0; b_gap = '0; b_rep = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        set_tag("reset_a", 0); push_vec(0, 0, 0, 0, 0, 0, 0); check_now();
        set_tag("reset_b", 1); push_vec(0, 0, 0, 0, 0, 0, 0); check_now();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Slots 0,2,3 back to back; complete at T+7.
        set_tag("basic_3021", 0);
        load_a(3, 0, 2, 1, 0, 0, 1);
        sync_pulse();
        drain();

        // Gap between slots and between passes, one repeat.
        set_tag("gap3_rep1", 0);
        load_a(2, 2, 0, 0, 3, 1, 1);
        sync_pulse();
        drain();

        // All lengths zero: only a complete pulse.
        set_tag("all_zero", 0);
        load_a(0, 0, 0, 0, 2, 0, 1);
        sync_pulse();
        drain();

        // Abort on tick 1 of slot 2.
        set_tag("abort_slot2", 0);
        load_a(2, 0, 3, 1, 1, 0, 1);
        sync_pulse();
        repeat (4) step_check();
        a_abort = 1'b1;
        exp_q.delete();
        push_idle(4);
        step_check();
        a_abort = 1'b0;
        drain();

        // Abort and sync together: sync is ignored.
        set_tag("abort_with_sync", 0);
        load_a(3, 0, 2, 1, 0, 0, 1);
        sync_pulse();
        step_check();
        load_a(1, 1, 1, 1, 0, 0, 0);
        a_abort = 1'b1;
        a_sync  = 1'b1;
        exp_q.delete();
        push_idle(4);
        step_check();
        a_abort = 1'b0;
        a_sync  = 1'b0;
        drain();

        // Inputs changed mid-frame do not disturb the running sequence.
        set_tag("len_change_run", 0);
        load_a(2, 1, 0, 2, 2, 0, 1);
        sync_pulse();
        repeat (2) step_check();
        load_a(1, 1, 1, 1, 0, 1, 0);
        drain();
        set_tag("len_change_next", 0);
        load_a(1, 1, 1, 1, 0, 1, 1);
        sync_pulse();
        drain();

        // Re-sync in the gap after slot 1: restart, no complete for old run.
        set_tag("resync_gap", 0);
        load_a(2, 2, 0, 0, 3, 1, 1);
        sync_pulse();
        repeat (7) step_check();
        exp_q.delete();
        load_a(2, 2, 0, 0, 3, 1, 1);
        sync_pulse();
        drain();

        // Random frames.
        for (int r = 0; r < 4; r++) begin
            set_tag("random", 0);
            load_a($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 1), 1);
            sync_pulse();
            drain();
        end

        // 16 slots, 4-bit lengths: only slot 15 at the maximum length 15.
        set_tag("n16_slot15_max", 1);
        lv = '{default: 0};
        lv[15] = 15;
        load_b(lv, 0, 0);
        sync_pulse();
        drain();

        set_tag("n16_two_slots", 1);
        lv = '{default: 0};
        lv[3] = 2;
        lv[15] = 15;
        load_b(lv, 1, 1);
        sync_pulse();
        drain();

        // Reset asserted mid-sequence clears outputs immediately.
        set_tag("mid_reset_a", 0);
        load_a(3, 0, 2, 1, 0, 0, 1);
        sync_pulse();
        step_check();
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        push_vec(0, 0, 0, 0, 0, 0, 0);
        check_now();
        set_tag("mid_reset_b", 1);
        push_vec(0, 0, 0, 0, 0, 0, 0);
        check_now();
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/time_slot_seq.md
Name: time_slot_seq

Overview:
- Parametrised frame sequencer; successor to the fixed 4-slot time-slot counter.
- On a sync pulse, steps through up to N_SLOTS programmable-length slots in ascending index order and skips zero-length slots.
- Adds a programmable idle gap between slots, a frame repeat count, abort, length shadowing and a busy flag.
- Sits between the sync/trigger source and the per-channel pulser/ADC capture logic; o_slot selects the active channel.

Parameters:
- N_SLOTS, 4, number of slots; range 2..16.
- LEN_W, 16, width of each slot length.
- GAP_W, 8, width of the inter-slot gap length.
- REP_W, 8, width of the frame repeat count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_sync  in  1  frame start pulse, one cycle.
- i_abort  in  1  terminate the sequence, one cycle.
- i_len  in  N_SLOTS*LEN_W  packed slot lengths; slot k = bits [k*LEN_W +: LEN_W]; 0 = skip the slot.
- i_gap  in  GAP_W  idle cycles inserted between consecutive active slots and between repeats.
- i_repeat  in  REP_W  extra frame passes after the first; 0 = single pass.
- o_slot  out  clog2(N_SLOTS)  index of the current slot; holds its last value while idle or in a gap.
- o_slot_active  out  1  high during slot cycles only.
- o_slot_sync  out  1  one-cycle pulse on the first cycle of each slot.
- o_frame_sync  out  1  one-cycle pulse on the first slot cycle of each frame pass.
- o_complete  out  1  one-cycle pulse when the sequence ends normally.
- o_busy  out  1  high from the first slot cycle until the sequence ends.
- o_tick  out  LEN_W  cycle index within the current slot, 0..len-1; 0 outside slots.

Behaviour:
- Reset: all outputs 0; state IDLE; shadow registers 0.
- All outputs are registered.
- States: IDLE, SLOT, GAP.
- i_sync (any state):
  - Latch i_len, i_gap and i_repeat into shadow registers; input changes after that cycle do not affect the running sequence.
  - Clear the pass counter.
  - Select the lowest-index nonzero slot.
  - Sync at cycle T: SLOT entered, with o_slot_sync = o_frame_sync = o_slot_active = o_busy = 1 and o_tick = 0 at T+1.
  - i_sync while busy restarts the sequence; no o_complete is emitted for the interrupted sequence.
- All latched lengths zero: no slot cycles; o_complete = 1 at T+1; o_busy stays 0.
- SLOT, length L: exactly L cycles with o_tick = 0..L-1. On the last cycle, choose the next nonzero slot with a higher index:
  - Exists and gap G > 0: GAP for G cycles, then SLOT.
  - Exists and G = 0: next SLOT on the immediately following cycle, with o_slot_sync pulsing again.
- No higher slot and pass < repeat: pass++, apply the same gap rule, restart at the lowest nonzero slot; o_frame_sync pulses again.
- No higher slot and pass == repeat: IDLE next cycle; o_complete = 1 for one cycle; o_busy = 0 on the same cycle.
- GAP: o_slot_active = 0; o_busy = 1; o_tick = 0.
- i_abort: IDLE next cycle; o_busy, o_slot_active and o_tick cleared; no o_complete.
- i_abort and i_sync in the same cycle: abort wins; the sync is ignored.
- Counters and arithmetic:
  - Counters are width-exact; no wrap is possible.
  - The length compare uses tick+1 == L, computed at LEN_W+1 bits.
  - L = 2^LEN_W-1 is supported.
- Total frame pass cycles = sum(L_k) + (n_active-1)*G. Passes are separated by G.
- Reset asserted mid-sequence: immediate return to reset values.

Decomposition:
- Package time_slot_pkg:
  - State enum: IDLE, SLOT, GAP.
  - Function clog2.
  - SLOT_W = clog2(N_SLOTS).
- Sub-module tss_next_slot (combinational):
  - Inputs: nonzero-slot mask and current index.
  - Outputs: next higher valid index with found flag, and lowest valid index with any flag.
  - Parametrised by N_SLOTS.

Test Plan:
- N_SLOTS=4, lengths {3,0,2,1}, gap 0, repeat 0, sync at T:
  - Slots 0 (T+1..T+3), 2 (T+4..T+5), 3 (T+6).
  - o_slot_sync at T+1, T+4, T+6.
  - o_complete at T+7.
- Lengths {2,2,0,0}, gap 3, repeat 1:
  - Slot0 2 cycles, 3 gap cycles, slot1 2, gap 3, then slot0, gap, slot1.
  - o_frame_sync twice; o_complete after 17 busy cycles.
- All lengths 0: o_complete at T+1; no o_slot_sync; o_busy never high.
- Abort on tick 1 of slot 2: IDLE next cycle; o_complete never pulses.
- Sync at the same cycle as abort is ignored.
- Change i_len mid-frame: running sequence unaffected; the next sync uses the new values.
- Re-sync during the slot-1 gap: restarts at slot 0 with o_frame_sync; no o_complete for the interrupted sequence.
- N_SLOTS=16, LEN_W=4, only slot 15 with length 15: slot 15 active 15 cycles; o_tick reaches 14; o_complete follows.
